// File: rtl/sa_out_collector.sv
// sa_out_collector: de-skews systolic-array column outputs into a row buffer,
// tracks a per-row signed max and streams rows out under valid/ready.
module sa_out_collector #(
   parameter int X_R      = 64,
   parameter int N_COL    = 64,
   parameter int SKEW_OFS = 64
) (
   input  logic                   I_CLK,
   input  logic                   I_RST_N,
   input  logic                   I_START_FLAG,
   input  logic                   I_IN_VLD,
   input  logic [N_COL*16-1:0]    I_IN,
   output logic                   O_ROW_VLD,
   input  logic                   I_ROW_RDY,
   output logic [N_COL*16-1:0]    O_ROW,
   output logic [$clog2(X_R)-1:0] O_ROW_IDX,
   output logic [15:0]            O_ROW_MAX,
   output logic                   O_BUSY,
   output logic                   O_DONE
);

   localparam int KW = $clog2(SKEW_OFS + X_R + N_COL);
   localparam int RW = $clog2(X_R);
   localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(SKEW_OFS + X_R + N_COL - 2);
   localparam logic [RW-1:0] R_LAST = RW'(X_R - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_e;

   state_e              state_q, state_d;
   logic [KW-1:0]       k_q;
   logic [15:0]         mem_q  [X_R][N_COL];
   logic [15:0]         rmax_q [X_R];
   logic [15:0]         rmax_d [X_R];
   logic [15:0]         in_col [N_COL];
   logic [CW-1:0]       col_sel [X_R];
   logic [X_R-1:0]      col_ok;
   logic                beat, enter_drain, hs, last_hs;
   logic [RW-1:0]       row_idx_q, ld_idx;
   logic [N_COL*16-1:0] row_q, ld_row;
   logic [15:0]         row_max_q, ld_max;
   logic                row_vld_q, done_q;

   assign beat        = (state_q == COLLECT) && I_IN_VLD && !I_START_FLAG;
   assign enter_drain = beat && (k_q == K_LAST);
   assign hs          = row_vld_q && I_ROW_RDY;
   assign last_hs     = hs && (row_idx_q == R_LAST);

   always_comb begin
      for (int c = 0; c < N_COL; c++) in_col[c] = I_IN[c*16 +: 16];
   end

   // Each row sees at most one lane per beat: col = k - SKEW_OFS - row.
   always_comb begin : p_lane
      int ci;
      for (int r = 0; r < X_R; r++) begin
         ci         = int'(k_q) - SKEW_OFS - r;
         col_ok[r]  = beat && (ci >= 0) && (ci < N_COL);
         col_sel[r] = CW'(ci);
         rmax_d[r]  = rmax_q[r];
         if (col_ok[r] &&
             ($signed(in_col[col_sel[r]]) > $signed(rmax_q[r])))
            rmax_d[r] = in_col[col_sel[r]];
      end
   end

   // Row 0 is loaded on the last beat, so forward that beat's write.
   always_comb begin
      ld_idx = enter_drain ? '0 : row_idx_q + 1'b1;
      for (int c = 0; c < N_COL; c++) ld_row[c*16 +: 16] = mem_q[ld_idx][c];
      ld_max = enter_drain ? rmax_d[0] : rmax_q[ld_idx];
      if (enter_drain && col_ok[0])
         ld_row[int'(col_sel[0])*16 +: 16] = in_col[col_sel[0]];
   end

   always_comb begin
      state_d = state_q;
      if (I_START_FLAG) begin
         state_d = COLLECT;
      end else begin
         case (state_q)
            COLLECT: if (enter_drain) state_d = DRAIN;
            DRAIN:   if (last_hs)     state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge I_CLK) begin
      for (int r = 0; r < X_R; r++)
         if (col_ok[r]) mem_q[r][col_sel[r]] <= in_col[col_sel[r]];
   end

   always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
         k_q       <= '0;
         row_idx_q <= '0;
         row_q     <= '0;
         row_max_q <= '0;
         row_vld_q <= 1'b0;
         done_q    <= 1'b0;
         for (int r = 0; r < X_R; r++) rmax_q[r] <= 16'h8000;
      end else begin
         done_q <= 1'b0;
         if (I_START_FLAG) begin
            k_q       <= '0;
            row_idx_q <= '0;
            row_vld_q <= 1'b0;
            for (int r = 0; r < X_R; r++) rmax_q[r] <= 16'h8000;
         end else begin
            if (beat) begin
               rmax_q <= rmax_d;
               if (!enter_drain) k_q <= k_q + 1'b1;
            end
            if (enter_drain) begin
               row_q     <= ld_row;
               row_max_q <= ld_max;
               row_idx_q <= '0;
               row_vld_q <= 1'b1;
            end else if (last_hs) begin
               row_vld_q <= 1'b0;
               done_q    <= 1'b1;
            end else if (hs) begin
               row_q     <= ld_row;
               row_max_q <= ld_max;
               row_idx_q <= ld_idx;
            end
         end
      end
   end

   assign O_ROW_VLD = row_vld_q;
   assign O_ROW     = row_q;
   assign O_ROW_IDX = row_idx_q;
   assign O_ROW_MAX = row_max_q;
   assign O_BUSY    = (state_q != IDLE);
   assign O_DONE    = done_q;

endmodule

// File: tb/tb_sa_out_collector.sv
// tb_sa_out_collector: table-driven small-config jobs plus a randomized
// full-size job checked against a matrix reference model.
`timescale 1ns/1ps
module tb_sa_out_collector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        s_rst_n, s_start, s_vld, s_rdy;
   logic [63:0] s_in, s_orow;
   logic        s_ovld, s_busy, s_done;
   logic [1:0]  s_oidx;
   logic [15:0] s_omax;

   logic          b_rst_n, b_start, b_vld, b_rdy;
   logic [1023:0] b_in, b_orow;
   logic          b_ovld, b_busy, b_done;
   logic [5:0]    b_oidx;
   logic [15:0]   b_omax;

   sa_out_collector #(.X_R(4), .N_COL(4), .SKEW_OFS(2)) u_small (
      .I_CLK(clk), .I_RST_N(s_rst_n), .I_START_FLAG(s_start),
      .I_IN_VLD(s_vld), .I_IN(s_in), .O_ROW_VLD(s_ovld),
      .I_ROW_RDY(s_rdy), .O_ROW(s_orow), .O_ROW_IDX(s_oidx),
      .O_ROW_MAX(s_omax), .O_BUSY(s_busy), .O_DONE(s_done)
   );

   sa_out_collector #(.X_R(64), .N_COL(64), .SKEW_OFS(64)) u_big (
      .I_CLK(clk), .I_RST_N(b_rst_n), .I_START_FLAG(b_start),
      .I_IN_VLD(b_vld), .I_IN(b_in), .O_ROW_VLD(b_ovld),
      .I_ROW_RDY(b_rdy), .O_ROW(b_orow), .O_ROW_IDX(b_oidx),
      .O_ROW_MAX(b_omax), .O_BUSY(b_busy), .O_DONE(b_done)
   );

   typedef struct packed {
      logic [3:0][15:0] v;
      logic [15:0]      mx;
   } row_t;

   row_t        tab [8];
   logic [15:0] bm  [64][64];

   function automatic row_t mk(input logic [15:0] a, b, c, d, mx);
      row_t t;
      t.v  = {d, c, b, a};
      t.mx = mx;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] s_lanes(input int base, input int k);
      logic [63:0] v;
      int r;
      for (int c = 0; c < 4; c++) begin
         r = k - 2 - c;
         v[c*16 +: 16] = (r >= 0 && r < 4) ? tab[base+r].v[c] : 16'hDEAD;
      end
      return v;
   endfunction

   task automatic start_small();
      s_start = 1'b1;
      s_vld   = 1'b0;
      @(negedge clk);
      s_start = 1'b0;
      chk("busy_after_start", 64'(s_busy), 64'd1);
   endtask

   task automatic feed_small(input int base, input int gap, input int n);
      int ev = 0;
      for (int k = 0; k < n; k++) begin
         if (s_ovld) ev++;
         s_vld = 1'b1;
         s_in  = s_lanes(base, k);
         @(negedge clk);
         if (gap > 0 && k < n - 1) begin
            s_vld = 1'b0;
            s_in  = {$urandom, $urandom};
            repeat (gap) begin
               if (s_ovld) ev++;
               @(negedge clk);
            end
         end
      end
      chk("early_vld", 64'(ev), 64'd0);
   endtask

   task automatic drain_small(input int base, input int rmode);
      logic [63:0] sv_row;
      logic [15:0] sv_max;
      logic [1:0]  sv_idx;
      bit hold = 0;
      int hs = 0, cyc = 0, dn = 0;
      chk("first_vld", 64'(s_ovld), 64'd1);
      while (hs < 4 && cyc < 100) begin
         if (cyc > 0) @(negedge clk);
         s_vld = 1'b0;
         if (s_done) dn++;
         if (hold) begin
            chk("hold_row", s_orow, sv_row);
            chk("hold_idx", 64'(s_oidx), 64'(sv_idx));
            chk("hold_max", 64'(s_omax), 64'(sv_max));
         end
         s_rdy = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (s_ovld && s_rdy) begin
            chk("row_data", s_orow, tab[base+hs].v);
            chk("row_idx", 64'(s_oidx), 64'(hs));
            chk("row_max", 64'(s_omax), 64'(tab[base+hs].mx));
            hs++;
         end
         hold   = s_ovld && !s_rdy;
         sv_row = s_orow;
         sv_idx = s_oidx;
         sv_max = s_omax;
         cyc++;
      end
      if (hs < 4) chk("drain_timeout", 64'(hs), 64'd4);
      @(negedge clk);
      s_rdy = 1'b0;
      chk("done_pulse", 64'(s_done), 64'd1);
      chk("busy_low", 64'(s_busy), 64'd0);
      chk("no_early_done", 64'(dn), 64'd0);
      @(negedge clk);
      chk("done_single", 64'(s_done), 64'd0);
   endtask

   initial begin
      int hs, cyc, dn, ev, cnt, r;
      logic [15:0] mx;

      tab[0] = mk(16'd0,  16'd1,  16'd2,  16'd3,  16'd3);
      tab[1] = mk(16'd16, 16'd17, 16'd18, 16'd19, 16'd19);
      tab[2] = mk(16'd32, 16'd33, 16'd34, 16'd35, 16'd35);
      tab[3] = mk(16'd48, 16'd49, 16'd50, 16'd51, 16'd51);
      tab[4] = mk(16'h7FFF, 16'h0000, 16'h8001, 16'hFFFF, 16'h7FFF);
      tab[5] = mk(16'hE000, 16'hF000, 16'hC000, 16'hF800, 16'hF800);
      tab[6] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
      tab[7] = mk(16'h0001, 16'hFFFF, 16'h8000, 16'h0000, 16'h0001);

      s_rst_n = 0; s_start = 0; s_vld = 0; s_rdy = 0; s_in = '0;
      b_rst_n = 0; b_start = 0; b_vld = 0; b_rdy = 0; b_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_vld", 64'(s_ovld), 64'd0);
      chk("rst_row", s_orow, 64'd0);
      chk("rst_idx", 64'(s_oidx), 64'd0);
      chk("rst_max", 64'(s_omax), 64'd0);
      chk("rst_busy", 64'(s_busy), 64'd0);
      chk("rst_done", 64'(s_done), 64'd0);
      chk("big_rst_row", 64'(b_orow != '0), 64'd0);
      chk("big_rst_misc", {b_ovld, b_busy, b_done, b_oidx, b_omax}, 64'd0);
      s_rst_n = 1;
      b_rst_n = 1;
      @(negedge clk);

      // basic, signed, backpressure, gapped beats
      start_small(); feed_small(0, 0, 9); drain_small(0, 0);
      start_small(); feed_small(4, 0, 9); drain_small(4, 0);
      start_small(); feed_small(4, 0, 9); drain_small(4, 1);
      start_small(); feed_small(0, 3, 9); drain_small(0, 0);

      // restart with a coincident beat at k=5, then a full new job
      start_small();
      feed_small(0, 0, 5);
      s_start = 1'b1;
      s_vld   = 1'b1;
      s_in    = s_lanes(0, 5);
      @(negedge clk);
      s_start = 1'b0;
      chk("restart_busy", 64'(s_busy), 64'd1);
      feed_small(4, 0, 9);
      drain_small(4, 0);

      // reset while row 2 is presented
      start_small();
      feed_small(0, 0, 9);
      s_rdy = 1'b1;
      cnt = 0;
      while (!(s_ovld && s_oidx == 2'd2) && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("rst_reach_row2", 64'(s_oidx), 64'd2);
      s_rst_n = 1'b0;
      #1;
      chk("arst_vld", 64'(s_ovld), 64'd0);
      chk("arst_row", s_orow, 64'd0);
      chk("arst_idx", 64'(s_oidx), 64'd0);
      chk("arst_max", 64'(s_omax), 64'd0);
      chk("arst_busy", 64'(s_busy), 64'd0);
      dn = 0;
      repeat (3) begin @(negedge clk); if (s_done) dn++; end
      s_rst_n = 1'b1;
      repeat (3) begin @(negedge clk); if (s_done) dn++; end
      chk("arst_no_done", 64'(dn), 64'd0);
      chk("arst_idle_vld", 64'(s_ovld), 64'd0);
      s_rdy = 1'b0;

      // full-size random job
      for (int i = 0; i < 64; i++)
         for (int j = 0; j < 64; j++) bm[i][j] = 16'($urandom);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      chk("big_busy", 64'(b_busy), 64'd1);
      ev = 0;
      for (int k = 0; k <= 190; k++) begin
         if (b_ovld) ev++;
         b_vld = 1'b1;
         for (int c = 0; c < 64; c++) begin
            r = k - 64 - c;
            b_in[c*16 +: 16] = (r >= 0 && r < 64) ? bm[r][c] : 16'($urandom);
         end
         @(negedge clk);
      end
      b_vld = 1'b0;
      chk("big_early_vld", 64'(ev), 64'd0);
      chk("big_first_vld", 64'(b_ovld), 64'd1);
      hs = 0; cyc = 0; dn = 0;
      while (hs < 64 && cyc < 2000) begin
         if (cyc > 0) @(negedge clk);
         if (b_done) dn++;
         b_rdy = 1'($urandom_range(0, 1));
         if (b_ovld && b_rdy) begin
            mx = 16'h8000;
            for (int c = 0; c < 64; c++)
               if ($signed(bm[hs][c]) > $signed(mx)) mx = bm[hs][c];
            chk("big_idx", 64'(b_oidx), 64'(hs));
            chk("big_max", 64'(b_omax), 64'(mx));
            for (int c = 0; c < 64; c++)
               chk("big_elem", 64'(b_orow[c*16 +: 16]), 64'(bm[hs][c]));
            hs++;
         end
         cyc++;
      end
      if (hs < 64) chk("big_timeout", 64'(hs), 64'd64);
      @(negedge clk);
      b_rdy = 1'b0;
      chk("big_done", 64'(b_done), 64'd1);
      chk("big_no_early_done", 64'(dn), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sa_out_collector.md
# sa_out_collector

Output de-skew and row buffer downstream of the systolic-array wrapper. It captures the skewed column outputs the array shifts out on each PE-shift beat and reassembles them into an X_R × N_COL result matrix. Per row, it tracks the signed maximum for the following softmax stage. Once the matrix is complete, it streams rows out under a valid/ready handshake.

## Interface
- X_R, 64, result rows per job (matches array X_R).
- N_COL, 64, result columns (array width).
- SKEW_OFS, 64, valid beats after start before element (row 0, col 0) appears; set by the integrator to the array pipeline depth S.
- I_CLK  in  1  clock.
- I_RST_N  in  1  asynchronous active-low reset.
- I_START_FLAG  in  1  single-cycle job start; same pulse that starts the array.
- I_IN_VLD  in  1  array output beat (array PE-shift strobe).
- I_IN  in  N_COL*16  array output row; col c at bits [c*16+:16], signed Q2.13.
- O_ROW_VLD  out  1  output row valid.
- I_ROW_RDY  in  1  consumer ready.
- O_ROW  out  N_COL*16  result row, same packing as I_IN.
- O_ROW_IDX  out  $clog2(X_R)  index of O_ROW.
- O_ROW_MAX  out  16  signed max of O_ROW.
- O_BUSY  out  1  high in COLLECT or DRAIN.
- O_DONE  out  1  one-cycle pulse after the last row handshake.

## Operation
- States are IDLE, COLLECT, DRAIN.
- Beat counter k (width $clog2(SKEW_OFS+X_R+N_COL)) counts accepted I_IN_VLD beats in COLLECT, starting from 0.
- On a beat with count k, for each column c let r = k − SKEW_OFS − c.
  - If 0 ≤ r < X_R, write mem[r][c] ← I_IN[c].
  - On the same beat, update rmax[r] ← max_signed(rmax[r], I_IN[c]).
  - Within one beat each c maps to a distinct r, so each row takes at most one compare per beat.
- Last useful beat is K_LAST = SKEW_OFS + X_R + N_COL − 2.
- The beat with k = K_LAST moves the state to DRAIN. Beats after that are ignored.
- I_START_FLAG behaves the same in any state: k←0, rmax[*]←16'h8000, row_idx←0, O_ROW_VLD←0, state←COLLECT. mem is not cleared.
- I_START_FLAG has priority over a coincident I_IN_VLD; that beat is discarded.
- I_IN_VLD is ignored in IDLE and DRAIN.
- DRAIN:
  - O_ROW = mem[row_idx], O_ROW_MAX = rmax[row_idx], O_ROW_IDX = row_idx. All three are registered.
  - A handshake is O_ROW_VLD & I_ROW_RDY. On a handshake, row_idx increments and the outputs load the next row.
  - After the handshake of row X_R−1: O_ROW_VLD←0, O_DONE pulses, state←IDLE.
- O_ROW_VLD, once high, stays high with stable O_ROW/O_ROW_IDX/O_ROW_MAX until the handshake. The only exceptions are I_START_FLAG and reset.
- Max compare is a two's-complement signed compare. There is no arithmetic on data, so there is no rounding or saturation.

## Timing
- Reset values:
  - O_ROW_VLD = 0, O_ROW = 0, O_ROW_IDX = 0, O_ROW_MAX = 0, O_BUSY = 0, O_DONE = 0.
  - Internal state: state = IDLE, k = 0, rmax[*] = 16'h8000.
- Reset mid-job aborts immediately to IDLE. No O_DONE is produced.
- O_BUSY goes high the cycle after I_START_FLAG.
- Gaps in I_IN_VLD are tolerated. Only beats advance k.
- Beat K_LAST at cycle t gives O_ROW_VLD = 1 with row 0 at cycle t+1.
- With I_ROW_RDY tied high, one row is delivered per cycle. Row X_R−1 handshakes at t+X_R.
- O_DONE is high at cycle t+X_R+1. O_BUSY is low from t+X_R+1.
- A start pulse during DRAIN discards the remaining rows without an O_DONE.

## Test plan
- Basic drain, X_R=4, N_COL=4, SKEW_OFS=2:
  - Stimulus: feed a skewed matrix with element(r,c)=16*r+c on beats k=2+r+c, continuous I_IN_VLD; unused lanes carry 16'hDEAD.
  - Required: rows 0..3 are emitted in order with exact values and no 16'hDEAD; O_ROW_MAX = 16*r+3; O_DONE pulses once.
- Signed max:
  - Stimulus: row 1 = {−1.0 (16'hE000), −0.5 (16'hF000), −2.0 (16'hC000), −0.25 (16'hF800)}.
  - Required: O_ROW_MAX = 16'hF800 for row 1.
- Backpressure:
  - Stimulus: I_ROW_RDY toggles 1,0,0,1,…
  - Required: O_ROW/O_ROW_IDX/O_ROW_MAX stay stable while RDY=0; no row is skipped or duplicated; O_DONE comes after the 4th handshake.
- Beat gaps:
  - Stimulus: I_IN_VLD low for 3 cycles between every beat.
  - Required: output identical to the basic drain scenario.
- Restart and reset:
  - Stimulus: I_START_FLAG at beat k=5, then a full new job.
  - Required: only the new job's data and max are output; a single O_DONE.
  - Stimulus: I_RST_N low during DRAIN row 2.
  - Required: all outputs return to 0 and no O_DONE.
- Full size, X_R=64, N_COL=64, SKEW_OFS=64:
  - Stimulus: random data.
  - Required: all 4096 elements match the reference model; O_ROW_VLD is first high one cycle after beat 190.
